// File: rtl/chan_sel_pipe.sv
// Per-channel source select/invert with agree/flag summary, 2-stage valid/ready pipeline (2-cycle latency).
// Stages advance only when empty or draining; out_valid and S2 data hold while out_ready is low.
module chan_sel_pipe #(
   parameter int NCH   = 4,
   parameter int W     = 1,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NCH-1:0]       sel,
   input  logic [NCH-1:0]       mode,
   input  logic [W-1:0]         d_a,
   input  logic [W-1:0]         d_b,
   input  logic [W-1:0]         d_c,
   input  logic [W-1:0]         d_d,
   input  logic                 en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NCH*W-1:0]     res,
   output logic                 agree,
   output logic                 flag,
   input  logic                 clr,
   output logic [CNT_W-1:0]     mismatch_cnt
);

   logic                 r_s1_vld;
   logic [NCH-1:0]       r_sel;
   logic [NCH-1:0]       r_mode;
   logic [W-1:0]         r_da;
   logic [W-1:0]         r_db;
   logic [W-1:0]         r_dc;
   logic [W-1:0]         r_dd;
   logic                 r_en;

   logic                 r_s2_vld;
   logic [NCH*W-1:0]     r_res;
   logic                 r_agree;
   logic                 r_flag;
   logic [CNT_W-1:0]     r_cnt;

   logic                 w_s2_adv;
   logic                 w_s1_adv;
   logic                 w_in_acc;
   logic                 w_xfer;
   logic [NCH*W-1:0]     w_res;
   logic                 w_agree;

   assign w_s2_adv = !r_s2_vld || out_ready;
   assign w_s1_adv = r_s1_vld && w_s2_adv;
   assign in_ready = !r_s1_vld || w_s1_adv;
   assign w_in_acc = in_valid && in_ready;
   assign w_xfer   = r_s2_vld && out_ready;

   always_comb begin
      w_res   = '0;
      w_agree = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (r_mode[i])
            w_res[i*W +: W] = r_sel[i] ? ~r_dc : ~r_dd;
         else
            w_res[i*W +: W] = r_sel[i] ? r_da : r_db;
      end
      for (int i = 1; i < NCH; i++) begin
         if (w_res[i*W +: W] != w_res[W-1:0])
            w_agree = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_sel    <= '0;
         r_mode   <= '0;
         r_da     <= '0;
         r_db     <= '0;
         r_dc     <= '0;
         r_dd     <= '0;
         r_en     <= 1'b0;
      end else if (in_ready) begin
         r_s1_vld <= in_valid;
         if (w_in_acc) begin
            r_sel  <= sel;
            r_mode <= mode;
            r_da   <= d_a;
            r_db   <= d_b;
            r_dc   <= d_c;
            r_dd   <= d_d;
            r_en   <= en;
         end
      end
   end

   // S2 data only reloads when a real beat moves in, so a drained stage keeps its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_res    <= '0;
         r_agree  <= 1'b0;
         r_flag   <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_vld <= r_s1_vld;
         if (w_s1_adv) begin
            r_res   <= w_res;
            r_agree <= w_agree;
            r_flag  <= r_en && !w_agree;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr)
         r_cnt <= '0;
      else if (w_xfer && !r_agree && (r_cnt != {CNT_W{1'b1}}))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign out_valid    = r_s2_vld;
   assign res          = r_res;
   assign agree        = r_agree;
   assign flag         = r_flag;
   assign mismatch_cnt = r_cnt;

endmodule

// File: tb/tb_chan_sel_pipe.sv
// Scoreboard bench for chan_sel_pipe: expected beats queued on acceptance, checked on delivery.
module tb_chan_sel_pipe;
   localparam int NCH   = 4;
   localparam int W     = 1;
   localparam int CNT_W = 2;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [NCH-1:0]       sel;
   logic [NCH-1:0]       mode;
   logic [W-1:0]         d_a, d_b, d_c, d_d;
   logic                 en;
   logic                 out_valid;
   logic                 out_ready;
   logic [NCH*W-1:0]     res;
   logic                 agree;
   logic                 flag;
   logic                 clr;
   logic [CNT_W-1:0]     mismatch_cnt;

   chan_sel_pipe #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .d_a(d_a), .d_b(d_b), .d_c(d_c), .d_d(d_d),
      .en(en), .out_valid(out_valid), .out_ready(out_ready), .res(res),
      .agree(agree), .flag(flag), .clr(clr), .mismatch_cnt(mismatch_cnt)
   );

   typedef struct {
      logic [NCH*W-1:0] res;
      logic             agree;
      logic             flag;
   } exp_t;

   exp_t             sb[$];
   int               n_chk  = 0;
   int               n_pass = 0;
   int               n_deliv = 0;
   bit               mon_on = 0;
   logic [CNT_W-1:0] m_cnt = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [NCH-1:0] s, input logic [NCH-1:0] m,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c, input logic [W-1:0] d, input logic e);
      exp_t r;
      logic [W-1:0] ch;
      r.res   = '0;
      r.agree = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (m[i] == 1'b0) ch = s[i] ? a : b;
         else              ch = s[i] ? ~c : ~d;
         r.res[i*W +: W] = ch;
      end
      for (int i = 1; i < NCH; i++)
         if (r.res[i*W +: W] !== r.res[W-1:0]) r.agree = 1'b0;
      r.flag = e && !r.agree;
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic mis;
      if (mon_on) begin
         n_chk++;
         if (mismatch_cnt !== m_cnt)
            $display("FAIL cnt_track: got %0d want %0d at %0t", mismatch_cnt, m_cnt, $time);
         else n_pass++;
         if (rst) begin
            sb.delete();
            m_cnt = '0;
         end else begin
            mis = 1'b0;
            if (out_valid && out_ready) begin
               n_deliv++;
               n_chk++;
               if (sb.size() == 0) begin
                  $display("FAIL unexpected_beat: res=%b with empty scoreboard at %0t", res, $time);
               end else begin
                  e = sb.pop_front();
                  mis = !e.agree;
                  if (res !== e.res || agree !== e.agree || flag !== e.flag)
                     $display("FAIL beat: got res=%b agree=%b flag=%b want res=%b agree=%b flag=%b at %0t",
                              res, agree, flag, e.res, e.agree, e.flag, $time);
                  else n_pass++;
               end
            end
            if (clr) m_cnt = '0;
            else if (mis && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            if (in_valid && in_ready) sb.push_back(model(sel, mode, d_a, d_b, d_c, d_d, en));
         end
      end
   end

   task automatic send(input logic [NCH-1:0] s, input logic [NCH-1:0] m,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d, input logic e);
      sel = s; mode = m; d_a = a; d_b = b; d_c = c; d_d = d; en = e;
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      n_chk++;
      $display("FAIL send_timeout: in_ready stayed 0, needed 1");
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || res !== '0 || agree !== 1'b0 || flag !== 1'b0 || mismatch_cnt !== '0)
         $display("FAIL reset_state: ov=%b res=%b agree=%b flag=%b cnt=%0d want all 0",
                  out_valid, res, agree, flag, mismatch_cnt);
      else n_pass++;
      rst = 1'b0;
      mon_on = 1;
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if (out_valid !== 1'b0) $display("FAIL basic_lat1: out_valid=%b want 0", out_valid);
      else n_pass++;
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || res !== 4'b0101 || agree !== 1'b0 || flag !== 1'b1)
         $display("FAIL basic_out: ov=%b res=%b agree=%b flag=%b want 1 0101 0 1", out_valid, res, agree, flag);
      else n_pass++;
      @(posedge clk); #1;
      n_chk++;
      if (mismatch_cnt !== 2'd1) $display("FAIL basic_cnt: got %0d want 1", mismatch_cnt);
      else n_pass++;
   endtask

   task automatic test_inverted();
      send(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || res !== 4'b1111 || agree !== 1'b1 || flag !== 1'b0)
         $display("FAIL inv_out: ov=%b res=%b agree=%b flag=%b want 1 1111 1 0", out_valid, res, agree, flag);
      else n_pass++;
      @(posedge clk); #1;
      n_chk++;
      if (mismatch_cnt !== 2'd1) $display("FAIL inv_cnt: got %0d want 1", mismatch_cnt);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = n_deliv;
      out_ready = 1'b0;
      send(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      sel = 4'b0111; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_chk++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || res !== 4'b0001)
            $display("FAIL stall_hold%0d: in_ready=%b ov=%b res=%b want 0 1 0001", k, in_ready, out_valid, res);
         else n_pass++;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready);
      else n_pass++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_chk++;
         if (out_valid !== 1'b1) $display("FAIL throughput%0d: out_valid=%b want 1", k, out_valid);
         else n_pass++;
      end
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (n_deliv - d0 !== 3) $display("FAIL b2b_count: delivered %0d want 3", n_deliv - d0);
      else n_pass++;
   endtask

   task automatic test_saturate();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      fork
         begin
            for (int k = 0; k < 5; k++)
               send(4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         end
         begin
            int seq[5] = '{1, 2, 3, 3, 3};
            logic [CNT_W-1:0] want;
            bit found = 0;
            int tries = 0;
            while (!found && tries < 30) begin
               @(negedge clk);
               tries++;
               if (out_valid === 1'b1) found = 1;
            end
            if (!found) begin
               n_chk++;
               $display("FAIL sat_timeout: out_valid never 1, needed 1");
            end else begin
               for (int j = 0; j < 5; j++) begin
                  @(negedge clk);
                  want = CNT_W'(seq[j]);
                  n_chk++;
                  if (mismatch_cnt !== want) $display("FAIL sat_seq%0d: got %0d want %0d", j, mismatch_cnt, want);
                  else n_pass++;
               end
            end
         end
      join
      @(posedge clk); #1;
   endtask

   task automatic test_clr();
      int d0;
      bit seen = 0;
      d0 = n_deliv;
      send(4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1;
      end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      n_chk++;
      if (!seen || mismatch_cnt !== 2'd0 || n_deliv - d0 !== 1)
         $display("FAIL clr_prio: seen=%0d cnt=%0d delivered=%0d want 1 0 1", seen, mismatch_cnt, n_deliv - d0);
      else n_pass++;
   endtask

   task automatic test_rst_flight();
      int d0;
      send(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (mismatch_cnt !== 2'd1) $display("FAIL flight_pre_cnt: got %0d want 1", mismatch_cnt);
      else n_pass++;
      out_ready = 1'b0;
      send(4'b0001, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      send(4'b1100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      d0 = n_deliv;
      rst = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_chk++;
      if (out_valid !== 1'b0 || mismatch_cnt !== 2'd0 || in_ready !== 1'b1)
         $display("FAIL flight_rst: ov=%b cnt=%0d in_ready=%b want 0 0 1", out_valid, mismatch_cnt, in_ready);
      else n_pass++;
      repeat (4) @(posedge clk);
      #1;
      n_chk++;
      if (n_deliv !== d0 || out_valid !== 1'b0)
         $display("FAIL flight_drop: delivered %0d ov=%b want 0 0", n_deliv - d0, out_valid);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; sel = '0; mode = '0;
      d_a = '0; d_b = '0; d_c = '0; d_d = '0; en = 1'b0;
      out_ready = 1'b1; clr = 1'b0;
      test_reset();
      test_basic();
      test_inverted();
      test_back_to_back();
      test_saturate();
      test_clr();
      test_rst_flight();
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (sb.size() != 0) $display("FAIL sb_drain: %0d beats outstanding want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/chan_sel_pipe.md
CHAN_SEL_PIPE -- requirements
Module: chan_sel_pipe

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of select channels (1..16).
REQ-002 SHALL have parameter W, default 1, meaning data width of each shared source bus (1..32).
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of the mismatch counter.
REQ-004 SHALL have port clk  input  1  sole clock; all flops sample on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  input beat offered.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port sel  input  NCH  per-channel source select.
REQ-009 SHALL have port mode  input  NCH  per-channel mode: 0 = direct, 1 = inverted.
REQ-010 SHALL have ports d_a, d_b, d_c, d_d  input  W each  shared source buses.
REQ-011 SHALL have port en  input  1  summary enable, captured with the beat.
REQ-012 SHALL have port out_valid  output  1  output beat present.
REQ-013 SHALL have port out_ready  input  1  output beat consumed when out_valid && out_ready.
REQ-014 SHALL have port res  output  NCH*W  per-channel results; channel i at bits [i*W +: W].
REQ-015 SHALL have port agree  output  1  all channel results equal.
REQ-016 SHALL have port flag  output  1  summary flag.
REQ-017 SHALL have port clr  input  1  synchronous clear of mismatch_cnt.
REQ-018 SHALL have port mismatch_cnt  output  CNT_W  saturating count of delivered non-agree beats.

Function
REQ-019 SHALL compute per channel i: mode=0 -> sel ? d_a : d_b; mode=1 -> sel ? ~d_c : ~d_d (bitwise over W).
REQ-020 SHALL use a two-stage pipeline: S1 registers the inputs; S2 registers res, agree and flag.
REQ-021 SHALL give a latency of exactly 2 cycles from input acceptance to out_valid when there is no stall.
REQ-022 SHALL set agree = 1 iff every channel result equals channel 0's result (NCH=1 -> always 1).
REQ-023 SHALL set flag = en_captured && !agree.
REQ-024 SHALL advance each stage only when it is empty or the downstream stage advances in the same cycle.
REQ-025 SHALL drive in_ready = !S1_valid || S1 advances, combinationally, with no dependence on in_valid.
REQ-026 SHALL hold out_valid and the S2 data constant while out_valid && !out_ready.
REQ-027 SHALL give full throughput of one beat per cycle while out_ready stays 1.
REQ-028 SHALL neither drop nor duplicate beats under any out_ready pattern; delivery is in order.
REQ-029 SHALL increment mismatch_cnt by 1 on each output transfer with agree=0.
REQ-030 SHALL hold mismatch_cnt at 2^CNT_W-1 once it saturates.
REQ-031 SHALL let clr take priority over a simultaneous increment, giving 0 the next cycle.
REQ-032 SHALL leave pipeline contents unchanged when clr is asserted.

Reset
REQ-033 SHALL, while rst=1 at a clock edge, clear S1_valid, S2_valid (out_valid=0), res, agree, flag and mismatch_cnt to 0.
REQ-034 SHALL, on rst asserted mid-operation, discard in-flight beats; no transfer occurs in the reset cycle.
REQ-035 SHALL hold in_ready = 1 from the first cycle after rst deasserts.

Verification
REQ-036 SHALL cover: NCH=4, W=1, mode=0000, sel=0101, d_a=1, d_b=0, en=1, out_ready=1 -> 2 cycles later res=0101, agree=0, flag=1, mismatch_cnt=1 after transfer.
REQ-037 SHALL cover: mode=1111, sel=0000, d_d=0 -> res=1111, agree=1, flag=0, counter unchanged.
REQ-038 SHALL cover: three back-to-back beats with out_ready=0 for 4 cycles -> in_ready=0 after 2 beats are held; release delivers all 3 in order, with the third accepted after the stall ends.
REQ-039 SHALL cover: CNT_W=2 with 5 non-agree transfers -> mismatch_cnt sequence 1,2,3,3,3.
REQ-040 SHALL cover: clr on the same cycle as a non-agree transfer -> mismatch_cnt=0 next cycle.
REQ-041 SHALL cover: rst pulsed while 2 beats are in flight -> out_valid=0 the next cycle, no beat delivered, mismatch_cnt=0.
